// File: rtl/fabric_config_loader.sv
// Loads the fabric configuration image from a ROM and broadcasts each word over a
// ready/valid config bus to every target that shares it, holding the fabric meanwhile.
module fabric_config_loader #(
   parameter int DATA_W    = 33,
   parameter int N_WORDS   = 14,
   parameter int ADDR_W    = 4,
   parameter int N_TARGETS = 58,
   parameter int TGT_W     = 6
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              start,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              cfg_valid,
   output logic [TGT_W-1:0]  cfg_target,
   output logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_ready,
   output logic              busy,
   output logic              fabric_hold,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   word;
   logic [TGT_W-1:0]    target;
   logic [DATA_W-1:0]   data_q;
   logic                last_tgt;

   // Word-to-target map: words 4..11 each feed a single lt LUT at 41..48.
   function automatic logic [TGT_W-1:0] first_target(input logic [ADDR_W-1:0] w);
      case (w)
         4'd0:    return TGT_W'(0);
         4'd1:    return TGT_W'(1);
         4'd2:    return TGT_W'(9);
         4'd3:    return TGT_W'(33);
         4'd12:   return TGT_W'(49);
         4'd13:   return TGT_W'(54);
         default: return TGT_W'(w) + TGT_W'(37);
      endcase
   endfunction

   function automatic logic [TGT_W-1:0] last_target(input logic [ADDR_W-1:0] w);
      case (w)
         4'd0:    return TGT_W'(0);
         4'd1:    return TGT_W'(8);
         4'd2:    return TGT_W'(32);
         4'd3:    return TGT_W'(40);
         4'd12:   return TGT_W'(53);
         4'd13:   return TGT_W'(N_TARGETS - 1);
         default: return TGT_W'(w) + TGT_W'(37);
      endcase
   endfunction

   assign last_tgt = (target == last_target(word));

   // NOTE: state is held in flops updated only with non-blocking assignments, so every
   // flop samples the pre-edge values; the async clear forces IDLE without a clock.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = FETCH;
         FETCH:      state_nx = READ;
         READ:       state_nx = WRITE;
         WRITE: begin
            if (cfg_ready && last_tgt)
               state_nx = (word == LAST_WORD) ? DONE : FETCH;
         end
         default:    state_nx = IDLE;
      endcase
   end

   // Word/target counters and the latched config word.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         word   <= '0;
         target <= '0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) word <= '0;
            READ: begin
               data_q <= rom_data;
               target <= first_target(word);
            end
            WRITE: begin
               if (cfg_ready) begin
                  if (!last_tgt)               target <= target + 1'b1;
                  else if (word != LAST_WORD)  word   <= word + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rom_en    = 1'b0;
      cfg_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         FETCH: begin
            rom_en = 1'b1;
            busy   = 1'b1;
         end
         READ:  busy = 1'b1;
         WRITE: begin
            cfg_valid = 1'b1;
            busy      = 1'b1;
         end
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign rom_addr    = word;
   assign cfg_target  = target;
   assign cfg_data    = data_q;
   assign fabric_hold = busy;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench for fabric_config_loader: random ROM images and ready patterns
// compared against a per-word broadcast model built from the word/target-count table.
module tb_fabric_config_loader;
   localparam int DATA_W    = 33;
   localparam int N_WORDS   = 14;
   localparam int ADDR_W    = 4;
   localparam int N_TARGETS = 58;
   localparam int TGT_W     = 6;
   localparam int CNT [N_WORDS] = '{1, 8, 24, 8, 1, 1, 1, 1, 1, 1, 1, 1, 5, 4};
   localparam int LOAD_CYCLES = 2 * N_WORDS + N_TARGETS;

   logic              clock;
   logic              clear = 1'b0;
   logic              start = 1'b0;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;
   logic              cfg_valid;
   logic [TGT_W-1:0]  cfg_target;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_ready = 1'b0;
   logic              busy, fabric_hold, done;

   logic [DATA_W-1:0] image [N_WORDS];
   logic [DATA_W-1:0] fab   [N_TARGETS];
   int                hs_tgt[$];
   logic [DATA_W-1:0] hs_data[$];
   int                exp_t[$];
   logic [DATA_W-1:0] exp_d[$];

   int   checks = 0, errors = 0;
   int   cyc = 0, t_fetch = 0;
   int   rom_reads = 0, done_rises = 0, stall_errs = 0;
   bit   rand_ready = 1'b0;
   logic ready_level = 1'b0;
   logic done_prev = 1'b0, stall_prev = 1'b0;
   logic [TGT_W-1:0]  prev_t = '0;
   logic [DATA_W-1:0] prev_d = '0;

   fabric_config_loader dut (
      .clock(clock), .clear(clear), .start(start),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .cfg_valid(cfg_valid), .cfg_target(cfg_target), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .busy(busy), .fabric_hold(fabric_hold), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous ROM: data valid the cycle after rom_en.
   always @(posedge clock) if (rom_en) rom_data <= image[rom_addr];

   always @(posedge clock) begin
      #1;
      cfg_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   // Passive monitor: handshakes, ROM reads, done edges and stall stability.
   always @(negedge clock) begin
      if (cfg_valid && cfg_ready) begin
         hs_tgt.push_back(int'(cfg_target));
         hs_data.push_back(cfg_data);
         fab[cfg_target] = cfg_data;
      end
      if (rom_en) rom_reads++;
      if (done && !done_prev) done_rises++;
      if (clear && stall_prev && (!cfg_valid || cfg_target !== prev_t || cfg_data !== prev_d))
         stall_errs++;
      stall_prev = clear && cfg_valid && !cfg_ready;
      prev_t     = cfg_target;
      prev_d     = cfg_data;
      done_prev  = done;
   end

   function automatic void new_image();
      for (int w = 0; w < N_WORDS; w++) image[w] = {1'($urandom()), 32'($urandom())};
      exp_t.delete();
      exp_d.delete();
      begin
         int t = 0;
         for (int w = 0; w < N_WORDS; w++)
            for (int c = 0; c < CNT[w]; c++) begin
               exp_t.push_back(t);
               exp_d.push_back(image[w]);
               t++;
            end
      end
   endfunction

   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      t_fetch = cyc;
   endtask

   task automatic wait_done(input int budget, output bit ok, output int t_done, output int hold_low);
      ok = 1'b0; t_done = 0; hold_low = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clock); #1;
         if (done) begin
            ok = 1'b1;
            t_done = cyc;
            break;
         end
         if (!fabric_hold) hold_low++;
      end
      @(negedge clock); #1;
   endtask

   task automatic test_reset();
      clear = 1'b0;
      #12;
      checks++;
      if ({rom_en, rom_addr, cfg_valid, cfg_target, cfg_data, busy, fabric_hold, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%b addr=%0d v=%b t=%0d d=%0h busy=%b hold=%b done=%b, expected all 0",
                  rom_en, rom_addr, cfg_valid, cfg_target, cfg_data, busy, fabric_hold, done);
      end
      @(posedge clock); #1 clear = 1'b1;
   endtask

   task automatic test_full_load();
      bit ok; int t_done, hold_low, hb, rb;
      new_image();
      rand_ready = 1'b0; ready_level = 1'b1;
      hb = hs_tgt.size(); rb = rom_reads;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || fabric_hold !== 1'b1) begin
         errors++; $display("FAIL full_busy: got busy=%b hold=%b, expected 1/1", busy, fabric_hold);
      end
      wait_done(300, ok, t_done, hold_low);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_done_timeout: got no done, expected done"); end
      checks++;
      if (t_done - t_fetch !== LOAD_CYCLES) begin
         errors++; $display("FAIL full_latency: got %0d expected %0d", t_done - t_fetch, LOAD_CYCLES);
      end
      checks++;
      if (hs_tgt.size() - hb !== N_TARGETS) begin
         errors++; $display("FAIL full_count: got %0d expected %0d", hs_tgt.size() - hb, N_TARGETS);
      end else begin
         for (int i = 0; i < N_TARGETS; i++) begin
            checks++;
            if (hs_tgt[hb+i] !== exp_t[i] || hs_data[hb+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL full_pair[%0d]: got t=%0d d=%0h expected t=%0d d=%0h",
                        i, hs_tgt[hb+i], hs_data[hb+i], exp_t[i], exp_d[i]);
            end
         end
         checks++;
         if (hs_data[hb] !== image[0] || hs_data[hb+20] !== image[2] || hs_data[hb+45] !== image[8]) begin
            errors++;
            $display("FAIL full_key_targets: got %0h/%0h/%0h expected %0h/%0h/%0h",
                     hs_data[hb], hs_data[hb+20], hs_data[hb+45], image[0], image[2], image[8]);
         end
      end
      checks++;
      if (rom_reads - rb !== N_WORDS) begin
         errors++; $display("FAIL full_rom_reads: got %0d expected %0d", rom_reads - rb, N_WORDS);
      end
   endtask

   task automatic test_random_ready();
      bit ok; int t_done, hold_low, hb, sb;
      new_image();
      rand_ready = 1'b1;
      hb = hs_tgt.size(); sb = stall_errs;
      pulse_start();
      wait_done(2000, ok, t_done, hold_low);
      rand_ready = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_done_timeout: got no done, expected done"); end
      checks++;
      if (hs_tgt.size() - hb !== N_TARGETS) begin
         errors++; $display("FAIL rand_count: got %0d expected %0d", hs_tgt.size() - hb, N_TARGETS);
      end else begin
         for (int i = 0; i < N_TARGETS; i++) begin
            checks++;
            if (hs_tgt[hb+i] !== exp_t[i] || hs_data[hb+i] !== exp_d[i]) begin
               errors++;
               $display("FAIL rand_pair[%0d]: got t=%0d d=%0h expected t=%0d d=%0h",
                        i, hs_tgt[hb+i], hs_data[hb+i], exp_t[i], exp_d[i]);
            end
         end
      end
      checks++;
      if (stall_errs - sb !== 0) begin
         errors++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stall_errs - sb);
      end
   endtask

   task automatic test_start_ignored();
      int hb, rb, db, t_done;
      bit ok;
      new_image();
      ready_level = 1'b1;
      hb = hs_tgt.size(); rb = rom_reads; db = done_rises;
      pulse_start();
      ok = 1'b0; t_done = 0;
      for (int i = 1; i < 300; i++) begin
         @(posedge clock); #1;
         start = (i == 5 || i == 40);
         if (done) begin ok = 1'b1; t_done = cyc; break; end
      end
      start = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if (!ok || t_done - t_fetch !== LOAD_CYCLES) begin
         errors++; $display("FAIL ign_latency: got %0d expected %0d", t_done - t_fetch, LOAD_CYCLES);
      end
      checks++;
      if (rom_reads - rb !== N_WORDS) begin
         errors++; $display("FAIL ign_rom_reads: got %0d expected %0d", rom_reads - rb, N_WORDS);
      end
      checks++;
      if (hs_tgt.size() - hb !== N_TARGETS) begin
         errors++; $display("FAIL ign_writes: got %0d expected %0d", hs_tgt.size() - hb, N_TARGETS);
      end
      checks++;
      if (done_rises - db !== 1) begin
         errors++; $display("FAIL ign_done_rises: got %0d expected 1", done_rises - db);
      end
   endtask

   task automatic test_mid_reset();
      bit found, ok; int hb, t_done, hold_low;
      new_image();
      ready_level = 1'b1;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (cfg_valid && cfg_target == TGT_W'(15)) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL mid_reach_t15: got not reached, expected target 15"); end
      clear = 1'b0;
      #1;
      checks++;
      if ({cfg_valid, busy, fabric_hold, done} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_async_clear: got v=%b busy=%b hold=%b done=%b expected 0000",
                  cfg_valid, busy, fabric_hold, done);
      end
      @(posedge clock); #1 clear = 1'b1;
      hb = hs_tgt.size();
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (hs_tgt.size() > hb) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL mid_first_write: got none, expected target 0");
      end else if (hs_tgt[hb] !== 0 || hs_data[hb] !== image[0]) begin
         errors++;
         $display("FAIL mid_first_write: got t=%0d d=%0h expected t=0 d=%0h", hs_tgt[hb], hs_data[hb], image[0]);
      end
      wait_done(300, ok, t_done, hold_low);
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_done_timeout: got no done, expected done"); end
   endtask

   task automatic test_reload();
      bit ok; int t_done, hold_low;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL reload_pre_done: got %b expected 1", done); end
      new_image();
      ready_level = 1'b1;
      pulse_start();
      checks++;
      if ({done, busy, fabric_hold} !== 3'b011) begin
         errors++; $display("FAIL reload_start_edge: got done/busy/hold=%b%b%b expected 011", done, busy, fabric_hold);
      end
      wait_done(300, ok, t_done, hold_low);
      checks++;
      if (!ok || hold_low !== 0) begin
         errors++; $display("FAIL reload_hold: got ok=%b low_cycles=%0d expected ok=1 low=0", ok, hold_low);
      end
      checks++;
      if (fabric_hold !== 1'b0) begin errors++; $display("FAIL reload_hold_after: got %b expected 0", fabric_hold); end
      for (int i = 0; i < N_TARGETS; i++) begin
         checks++;
         if (fab[exp_t[i]] !== exp_d[i]) begin
            errors++; $display("FAIL fabric_image[%0d]: got %0h expected %0h", exp_t[i], fab[exp_t[i]], exp_d[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_random_ready();
      test_start_ignored();
      test_mid_reset();
      test_reload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
